axi_dma_rd_arb: RTL and testbench
=================================

// Module: axi_dma_rd_arb
// PURPOSE
//  Shares one DDR AXI read channel (AR+R) between NUM_PORTS axi DMA read interfaces.
//  Round-robin arbitration on AR, one burst per grant; R beats routed back by rid.
//  Per-port outstanding-burst counters throttle each requester.
//  Sits between the per-stream DMA read interfaces and the DDR controller AXI slave port.
// PARAMETERS
//  NUM_PORTS        2    requesters; >=2, <=2**AXI_ID_WIDTH
//  AXI_ADDR_WIDTH   32   AR address width
//  AXI_DATA_WIDTH   128  R data width
//  AXI_ID_WIDTH     4    ID width; port i owns ID (ID_BASE+i)
//  AXI_BURST_WIDTH  6    arlen width
//  ID_BASE          4    ID of port 0
//  MAX_OUTSTANDING  2    max bursts in flight per port (1..15)
// PORTS
//  aclk            in   1                    clock
//  aresetn         in   1                    async reset, active low
//  s_arid          in   NUM_PORTS*ID_W       per-port AR id (slice i = [i*W +: W])
//  s_araddr        in   NUM_PORTS*ADDR_W     per-port AR address
//  s_arlen         in   NUM_PORTS*BURST_W    per-port AR length
//  s_arvalid       in   NUM_PORTS            per-port AR valid
//  s_arready       out  NUM_PORTS            per-port AR ready (one-hot pulse)
//  s_rid/rdata/rresp/rlast out ID_W/DATA_W/2/1  R payload, broadcast to all ports
//  s_rvalid        out  NUM_PORTS            per-port R valid
//  s_rready        in   NUM_PORTS            per-port R ready
//  m_arid/araddr/arlen out ID_W/ADDR_W/BURST_W  master AR payload (registered)
//  m_arvalid       out  1                    master AR valid (registered)
//  m_arready       in   1                    master AR ready
//  m_rid/rdata/rresp/rlast in ID_W/DATA_W/2/1 master R payload
//  m_rvalid        in   1                    master R valid
//  m_rready        out  1                    master R ready
//  err_unmapped    out  1                    sticky: R beat with rid outside port ID range
// BEHAVIOUR
//  Reset: m_arvalid=0, s_arready=0, all counters=0, rr pointer=0, err_unmapped=0, FSM=IDLE.
//  FSM IDLE: eligible = s_arvalid[i] & (cnt[i]<MAX_OUTSTANDING); if any, pick first eligible
//   at/after rr pointer, latch its AR payload, m_arvalid=1 next cycle -> HOLD.
//  FSM HOLD: payload/m_arvalid stable until m_arvalid&m_arready; that cycle s_arready[g]=1
//   (combinational), cnt[g]++, rr pointer=g+1 mod NUM_PORTS, -> IDLE. Min 2 cycles/grant.
//  Requester must keep s_arvalid and payload stable until its s_arready pulse.
//  R route: p = m_rid-ID_BASE; if 0<=p<NUM_PORTS: s_rvalid[p]=m_rvalid, m_rready=s_rready[p],
//   other s_rvalid=0. Purely combinational, zero latency, no R buffering.
//  Unmapped rid: m_rready=1 (beat dropped), all s_rvalid=0, err_unmapped set.
//  cnt[p]-- on m_rvalid&m_rready&m_rlast for mapped p; same-cycle inc+dec on one port -> no change.
//  Decrement at cnt==0 (spurious rlast) ignored, counter holds 0; never wraps; inc never exceeds max.
//  Reset mid-burst: everything cleared asynchronously; in-flight bursts are lost (system reset).
// CONFIGURATION
//  DMA_RD_ARB_FIXED_PRIO_EN defined: fixed priority, lowest port index wins; rr pointer unused.
//  Undefined (default): round-robin as above.
// STRUCTURE
//  Shared package dma_pkg: AR state enum (IDLE,HOLD), ID_BASE/MAX_OUTSTANDING defaults,
//   clog2-based counter width constant.
//  Sub-module rr_arbiter (NUM_PORTS req, one-hot grant, pointer advance on ack input);
//   fixed-priority variant selected inside it under the macro.
// TESTING
//  1 port0 only, arlen=7, m_arready=1: m_arvalid 1 cyc after s_arvalid; s_arready[0] pulse; cnt0=1.
//  2 both ports request continuously: grants alternate 0,1,0,1 (fixed-prio build: 0,0 until cnt0=2).
//  3 port0 issues 2 bursts, no R returned: 3rd request blocked, port1 still granted; rlast frees slot.
//  4 m_arready low 5 cycles: m_arvalid/araddr stable, no s_arready until ready rises.
//  5 R beats rid=5, s_rready[1]=0: s_rvalid[1]=1, m_rready=0; rid=9: dropped, err_unmapped=1.
//  6 aresetn low mid-HOLD and mid-R burst: outputs zero immediately; after release IDLE, cnt=0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA read-channel arbiter.
package dma_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } ar_state_t;

    localparam int DEF_ID_BASE         = 4;
    localparam int DEF_MAX_OUTSTANDING = 2;
    localparam int MAX_OUTSTANDING_LIM = 15;
    localparam int CNT_W               = $clog2(MAX_OUTSTANDING_LIM + 1);

endpackage

// File: rtl/rr_arbiter.sv
// One-hot request arbiter; round-robin by default, fixed lowest-index priority
// when DMA_RD_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter int NUM_PORTS = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 ack,
    input  logic [NUM_PORTS-1:0] ack_grant,
    output logic [NUM_PORTS-1:0] grant
);

`ifdef DMA_RD_ARB_FIXED_PRIO_EN

    logic unused_ok;
    assign unused_ok = ^{aclk, aresetn, ack, ack_grant};

    assign grant = req & (~req + NUM_PORTS'(1));

`else

    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ack_idx;
    logic [NUM_PORTS-1:0] hi_req;
    logic [NUM_PORTS-1:0] pick;

    // Requests at/after the pointer take precedence; otherwise wrap to the lowest.
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hi_req[i] = req[i] && (i >= int'(ptr));
        end
        pick  = (|hi_req) ? hi_req : req;
        grant = pick & (~pick + NUM_PORTS'(1));
    end

    always_comb begin
        ack_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ack_grant[i]) begin
                ack_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr <= '0;
        end else if (ack) begin
            ptr <= (ack_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : ack_idx + PTR_W'(1);
        end
    end

`endif

endmodule

// File: rtl/axi_dma_rd_arb.sv
// Shares one AXI read channel between NUM_PORTS DMA readers; R beats routed by rid.
// Build option: DMA_RD_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
//
// state   | meaning
// ST_IDLE | no AR pending; arbitrate eligible requesters each cycle
// ST_HOLD | latched AR presented on master port until m_arready
module axi_dma_rd_arb
    import dma_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_BURST_WIDTH = 6,
    parameter int ID_BASE         = DEF_ID_BASE,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [NUM_PORTS*AXI_ID_WIDTH-1:0]    s_arid,
    input  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0]  s_araddr,
    input  logic [NUM_PORTS*AXI_BURST_WIDTH-1:0] s_arlen,
    input  logic [NUM_PORTS-1:0]                 s_arvalid,
    output logic [NUM_PORTS-1:0]                 s_arready,
    output logic [AXI_ID_WIDTH-1:0]              s_rid,
    output logic [AXI_DATA_WIDTH-1:0]            s_rdata,
    output logic [1:0]                           s_rresp,
    output logic                                 s_rlast,
    output logic [NUM_PORTS-1:0]                 s_rvalid,
    input  logic [NUM_PORTS-1:0]                 s_rready,
    output logic [AXI_ID_WIDTH-1:0]              m_arid,
    output logic [AXI_ADDR_WIDTH-1:0]            m_araddr,
    output logic [AXI_BURST_WIDTH-1:0]           m_arlen,
    output logic                                 m_arvalid,
    input  logic                                 m_arready,
    input  logic [AXI_ID_WIDTH-1:0]              m_rid,
    input  logic [AXI_DATA_WIDTH-1:0]            m_rdata,
    input  logic [1:0]                           m_rresp,
    input  logic                                 m_rlast,
    input  logic                                 m_rvalid,
    output logic                                 m_rready,
    output logic                                 err_unmapped
);

    localparam int IW = AXI_ID_WIDTH;
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int BW = AXI_BURST_WIDTH;
    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_OUTSTANDING);

    ar_state_t            state;
    logic [NUM_PORTS-1:0] gsel;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [NUM_PORTS-1:0] dec;
    logic [NUM_PORTS-1:0] rid_hit;
    logic                 rid_mapped;
    logic                 ar_ack;
    logic                 r_done;
    logic [IW-1:0]        sel_id;
    logic [AW-1:0]        sel_addr;
    logic [BW-1:0]        sel_len;
    logic [CNT_W-1:0]     cnt [NUM_PORTS];

    assign ar_ack    = (state == ST_HOLD) && m_arvalid && m_arready;
    assign s_arready = ar_ack ? gsel : '0;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = s_arvalid[i] && (cnt[i] < MAXC);
        end
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req       (eligible),
        .ack       (ar_ack),
        .ack_grant (gsel),
        .grant     (arb_grant)
    );

    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_grant[i]) begin
                sel_id   = s_arid[i*IW +: IW];
                sel_addr = s_araddr[i*AW +: AW];
                sel_len  = s_arlen[i*BW +: BW];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            m_arvalid <= 1'b0;
            m_arid    <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            gsel      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|eligible) begin
                        m_arid    <= sel_id;
                        m_araddr  <= sel_addr;
                        m_arlen   <= sel_len;
                        m_arvalid <= 1'b1;
                        gsel      <= arb_grant;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rid_hit[i] = (int'(m_rid) == ID_BASE + i);
        end
    end

    // Unmapped beats are accepted and dropped so the DDR side never stalls.
    assign rid_mapped = |rid_hit;
    assign s_rvalid   = m_rvalid ? rid_hit : '0;
    assign m_rready   = rid_mapped ? |(rid_hit & s_rready) : 1'b1;
    assign s_rid      = m_rid;
    assign s_rdata    = m_rdata;
    assign s_rresp    = m_rresp;
    assign s_rlast    = m_rlast;
    assign r_done     = m_rvalid && m_rready && m_rlast;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            dec[i] = r_done && rid_hit[i] && (cnt[i] != '0);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (s_arready[i] && !dec[i] && (cnt[i] != MAXC)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (dec[i] && !s_arready[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_unmapped <= 1'b0;
        end else if (m_rvalid && !rid_mapped) begin
            err_unmapped <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_dma_rd_arb.sv
// Directed bench for axi_dma_rd_arb: R routing table plus AR arbitration sequences.
module tb_axi_dma_rd_arb;

    localparam int NP = 2;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int BW = 6;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [NP*IW-1:0] s_arid;
    logic [NP*AW-1:0] s_araddr;
    logic [NP*BW-1:0] s_arlen;
    logic [NP-1:0]    s_arvalid;
    logic [NP-1:0]    s_arready;
    logic [IW-1:0]    s_rid;
    logic [DW-1:0]    s_rdata;
    logic [1:0]       s_rresp;
    logic             s_rlast;
    logic [NP-1:0]    s_rvalid;
    logic [NP-1:0]    s_rready;
    logic [IW-1:0]    m_arid;
    logic [AW-1:0]    m_araddr;
    logic [BW-1:0]    m_arlen;
    logic             m_arvalid;
    logic             m_arready;
    logic [IW-1:0]    m_rid;
    logic [DW-1:0]    m_rdata;
    logic [1:0]       m_rresp;
    logic             m_rlast;
    logic             m_rvalid;
    logic             m_rready;
    logic             err_unmapped;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [IW-1:0] rid;
        logic          rvalid;
        logic [NP-1:0] rready;
        logic [NP-1:0] exp_rvalid;
        logic          exp_mready;
    } rvec_t;

    rvec_t rtab[8];
    int    exp_order[4];
    int    g;

    axi_dma_rd_arb dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_arid       (s_arid),
        .s_araddr     (s_araddr),
        .s_arlen      (s_arlen),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_rid        (s_rid),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rlast      (s_rlast),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .m_arid       (m_arid),
        .m_araddr     (m_araddr),
        .m_arlen      (m_arlen),
        .m_arvalid    (m_arvalid),
        .m_arready    (m_arready),
        .m_rid        (m_rid),
        .m_rdata      (m_rdata),
        .m_rresp      (m_rresp),
        .m_rlast      (m_rlast),
        .m_rvalid     (m_rvalid),
        .m_rready     (m_rready),
        .err_unmapped (err_unmapped)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        s_arid    = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        clear_inputs();
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic set_req(input int p, input logic [AW-1:0] addr, input logic [BW-1:0] len);
        s_arid[p*IW +: IW]   = IW'(4 + p);
        s_araddr[p*AW +: AW] = addr;
        s_arlen[p*BW +: BW]  = len;
    endtask

    // Returns the port whose s_arready pulses within budget cycles, or -1.
    task automatic next_grant(input int budget, output int port);
        port = -1;
        for (int c = 0; c < budget && port < 0; c++) begin
            @(negedge aclk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (s_arready[i]) port = i;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rtab[0] = '{4'd4, 1'b1, 2'b01, 2'b01, 1'b1};
        rtab[1] = '{4'd4, 1'b1, 2'b10, 2'b01, 1'b0};
        rtab[2] = '{4'd5, 1'b1, 2'b10, 2'b10, 1'b1};
        rtab[3] = '{4'd5, 1'b1, 2'b00, 2'b10, 1'b0};
        rtab[4] = '{4'd5, 1'b0, 2'b10, 2'b00, 1'b1};
        rtab[5] = '{4'd4, 1'b0, 2'b00, 2'b00, 1'b0};
        rtab[6] = '{4'd3, 1'b0, 2'b11, 2'b00, 1'b1};
        rtab[7] = '{4'd6, 1'b0, 2'b11, 2'b00, 1'b1};
`ifdef DMA_RD_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif

        aresetn = 1'b0;
        clear_inputs();
        #1;
        chk("reset_arvalid", m_arvalid, 0);
        chk("reset_arready", s_arready, 0);
        chk("reset_err", err_unmapped, 0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;

        // single burst from port 0
        @(negedge aclk);
        set_req(0, 32'h1000_0000, 6'd7);
        s_arvalid = 2'b01;
        m_arready = 1'b1;
        #1;
        chk("t1_arvalid_before", m_arvalid, 0);
        @(negedge aclk);
        #1;
        chk("t1_arvalid", m_arvalid, 1);
        chk("t1_araddr", m_araddr, 32'h1000_0000);
        chk("t1_arlen", m_arlen, 7);
        chk("t1_arid", m_arid, 4);
        chk("t1_arready", s_arready, 2'b01);
        @(negedge aclk);
        s_arvalid = 2'b00;
        #1;
        chk("t1_arvalid_after", m_arvalid, 0);
        chk("t1_arready_after", s_arready, 0);

        // port 0 reaches its outstanding limit
        set_req(0, 32'h2000_0000, 6'd3);
        s_arvalid = 2'b01;
        next_grant(8, g);
        chk("t3_second_grant", g, 0);
        chk("t3_second_addr", m_araddr, 32'h2000_0000);
        @(negedge aclk);
        set_req(0, 32'h3000_0000, 6'd3);
        set_req(1, 32'h5000_0000, 6'd1);
        s_arvalid = 2'b11;
        next_grant(8, g);
        chk("t3_port1_granted", g, 1);
        chk("t3_port1_arid", m_arid, 5);
        @(negedge aclk);
        s_arvalid = 2'b01;
        next_grant(6, g);
        chk("t3_port0_blocked", g, -1);
        chk("t3_blocked_arvalid", m_arvalid, 0);
        @(negedge aclk);
        m_rid    = 4'd4;
        m_rdata  = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        s_rready = 2'b01;
        #1;
        chk("t3_rlast_rvalid", s_rvalid, 2'b01);
        chk("t3_rlast_mready", m_rready, 1);
        chk("t3_rdata", s_rdata, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        next_grant(8, g);
        chk("t3_freed_grant", g, 0);
        chk("t3_freed_addr", m_araddr, 32'h3000_0000);
        @(negedge aclk);
        s_arvalid = 2'b00;

        // master stalls AR for five cycles
        do_reset();
        @(negedge aclk);
        set_req(1, 32'h4444_0000, 6'd3);
        s_arvalid = 2'b10;
        m_arready = 1'b0;
        @(negedge aclk);
        #1;
        chk("t4_arvalid_up", m_arvalid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            if (c == 1) begin
                set_req(0, 32'h1111_0000, 6'd2);
                s_arvalid = 2'b11;
            end
            #1;
            chk($sformatf("t4_hold_valid_%0d", c), m_arvalid, 1);
            chk($sformatf("t4_hold_addr_%0d", c), m_araddr, 32'h4444_0000);
            chk($sformatf("t4_no_ready_%0d", c), s_arready, 0);
        end
        @(negedge aclk);
        m_arready = 1'b1;
        #1;
        chk("t4_ready_pulse", s_arready, 2'b10);
        chk("t4_arid", m_arid, 5);
        @(negedge aclk);
        s_arvalid = 2'b01;
        next_grant(8, g);
        chk("t4_then_port0", g, 0);
        chk("t4_port0_addr", m_araddr, 32'h1111_0000);
        @(negedge aclk);
        s_arvalid = 2'b00;

        // both ports request continuously
        do_reset();
        @(negedge aclk);
        set_req(0, 32'h0A00_0000, 6'd15);
        set_req(1, 32'h0B00_0000, 6'd15);
        s_arvalid = 2'b11;
        m_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_grant(8, g);
            chk($sformatf("t2_grant_%0d", k), g, exp_order[k]);
        end
        next_grant(6, g);
        chk("t2_all_full", g, -1);
        @(negedge aclk);
        s_arvalid = 2'b00;

        // R routing table
        foreach (rtab[k]) begin
            @(negedge aclk);
            m_rid    = rtab[k].rid;
            m_rvalid = rtab[k].rvalid;
            m_rlast  = 1'b0;
            s_rready = rtab[k].rready;
            #1;
            chk($sformatf("t5_vec%0d_rvalid", k), s_rvalid, rtab[k].exp_rvalid);
            chk($sformatf("t5_vec%0d_mready", k), m_rready, rtab[k].exp_mready);
        end
        @(negedge aclk);
        m_rvalid = 1'b0;
        #1;
        chk("t5_err_clean", err_unmapped, 0);
        @(negedge aclk);
        m_rid    = 4'd9;
        m_rvalid = 1'b1;
        s_rready = 2'b00;
        #1;
        chk("t5_unmapped_rvalid", s_rvalid, 2'b00);
        chk("t5_unmapped_mready", m_rready, 1);
        chk("t5_err_not_yet", err_unmapped, 0);
        @(negedge aclk);
        m_rvalid = 1'b0;
        #1;
        chk("t5_err_set", err_unmapped, 1);

        // reset while an AR is held and an R burst is in flight
        @(negedge aclk);
        m_rid    = 4'd4;
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        s_rready = 2'b01;
        @(negedge aclk);
        m_rlast = 1'b0;
        set_req(0, 32'h6000_0000, 6'd2);
        s_arvalid = 2'b01;
        m_arready = 1'b0;
        @(negedge aclk);
        #1;
        chk("t6_in_hold", m_arvalid, 1);
        chk("t6_mid_burst", s_rvalid, 2'b01);
        #2;
        aresetn  = 1'b0;
        m_rvalid = 1'b0;
        #1;
        chk("t6_rst_arvalid", m_arvalid, 0);
        chk("t6_rst_arready", s_arready, 0);
        chk("t6_rst_araddr", m_araddr, 0);
        chk("t6_rst_err", err_unmapped, 0);
        chk("t6_rst_rvalid", s_rvalid, 0);
        @(negedge aclk);
        aresetn   = 1'b1;
        s_arvalid = 2'b00;
        m_arready = 1'b1;
        @(negedge aclk);
        #1;
        chk("t6_idle_after", m_arvalid, 0);
        @(negedge aclk);
        m_rid    = 4'd4;
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        #1;
        chk("t6_spurious_mready", m_rready, 1);
        @(negedge aclk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        set_req(0, 32'h7000_0000, 6'd1);
        s_arvalid = 2'b01;
        next_grant(8, g);
        chk("t6_grant_a", g, 0);
        next_grant(8, g);
        chk("t6_grant_b", g, 0);
        next_grant(6, g);
        chk("t6_limit_after_reset", g, -1);
        @(negedge aclk);
        s_arvalid = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
